alu: RTL and testbench
======================

Name: alu

Overview:
- 32-bit MIPS-style integer ALU used in each issue slot of the dual-issue execute stage.
- Computes a combinational result from two forwarded operands, a 6-bit ALU control code and a 5-bit shift amount (instruction bits 10:6).
- Owns architectural HI/LO registers, written on the clock edge by multiply, divide and move-to operations.

Parameters:
- none (width fixed at 32)

Ports:
- CLK  input  1  clock, rising edge
- RESET  input  1  asynchronous, active-low reset
- HI  output  32  HI register (registered)
- LO  output  32  LO register (registered)
- aluResult  output  32  combinational result
- OpA  input  32  operand A (rs)
- OpB  input  32  operand B (rt or immediate)
- ALU_control  input  6  operation select
- shamt  input  5  shift amount (Instr[10:6])

Behaviour:
- aluResult is purely combinational, zero latency. No internal state besides HI/LO.
- Encoding of ALU_control (hex):
  - 00 AND; 01 OR; 02 ADD; 03 ADDU; 04 XOR; 05 NOR; 06 SUB; 07 SUBU
  - 08 SLT (signed, result 1/0); 09 SLTU (unsigned)
  - 0A SLL: OpB<<shamt; 0B SRL: OpB>>shamt logical; 0C SRA: OpB>>>shamt arithmetic
  - 0D SLLV, 0E SRLV, 0F SRAV: as above, amount = OpA[4:0]
  - 10 LUI: {OpB[15:0],16'h0}
  - 11 MULT, 12 MULTU, 13 DIV, 14 DIVU
  - 15 MFHI: result=HI; 16 MFLO: result=LO
  - 17 MTHI; 18 MTLO; 19 PASSA: result=OpA; 1A PASSB: result=OpB
  - all other codes: result 0, HI/LO unchanged
- ADD/SUB wrap modulo 2^32. No overflow trap or flag; ADD≡ADDU and SUB≡SUBU in result.
- aluResult for 11-14, 17, 18 is 0.
- HI/LO update on rising CLK:
  - MULT/MULTU: {HI,LO} = 64-bit signed/unsigned product.
  - DIV/DIVU: LO = quotient, HI = remainder. Signed division truncates toward zero; remainder takes the sign of the dividend.
  - Divide by zero (OpB==0): HI/LO unchanged.
  - 0x80000000 / -1 (signed): LO=0x80000000, HI=0.
  - MTHI: HI=OpA. MTLO: LO=OpA. Any other code holds HI/LO.
- MFHI/MFLO read the current registered value. A write in cycle N is visible to MFHI/MFLO from cycle N+1.
- Reset: HI=0, LO=0 immediately on RESET low, independent of CLK. aluResult stays combinational during reset; MFHI/MFLO return 0.
- Reset deasserting mid-operation: the first rising edge with RESET high performs a normal update.
- Shift by 0 returns OpB unchanged. SRAV uses only OpA[4:0]; upper bits are ignored.

Decomposition:
- Shared package alu_pkg: localparam constants for all ALU_control codes (ALU_AND … ALU_PASSB) and the data width (32). The decoder/control stage imports the same constants.
- One natural sub-module: alu_hilo, which holds the HI/LO registers and the mult/div datapath. Division is a single-cycle combinational divider (simulation-oriented); shifts and logic stay in the top-level.

Test Plan:
- Reset: RESET=0 after HI/LO written -> HI=LO=0 asynchronously; code 15 then returns 0.
- Arithmetic/compare: ADD 7FFFFFFF+1 -> 80000000; SUB 0-1 -> FFFFFFFF; SLT FFFFFFFF,1 -> 1; SLTU FFFFFFFF,1 -> 0; NOR 0,0 -> FFFFFFFF.
- Shifts: SLL OpB=1,shamt=31 -> 80000000; SRA OpB=80000000,shamt=4 -> F8000000; SRLV OpA=0x24 (amt 4),OpB=F0 -> 0F; LUI OpB=1234 -> 12340000.
- Multiply: MULT FFFFFFFF×2 then clock -> HI=FFFFFFFF,LO=FFFFFFFE; MULTU same operands -> HI=1,LO=FFFFFFFE; next-cycle MFHI/MFLO return these.
- Divide: DIV -7/2 -> LO=FFFFFFFD,HI=FFFFFFFF; DIVU 7/2 -> LO=3,HI=1; DIV by 0 -> HI/LO unchanged; 80000000/FFFFFFFF -> LO=80000000,HI=0.
- Move/hold: MTHI A5A5A5A5, MTLO 5A5A5A5A -> MFHI/MFLO return them. An ADD cycle in between does not alter HI/LO. Undefined code 3F -> result 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU control codes and width for the execute stage and its decoder.
// Also provides a small helper that tells whether a code updates HI/LO.
package alu_pkg;

   localparam int DATA_W = 32;

   localparam logic [5:0] ALU_AND   = 6'h00;
   localparam logic [5:0] ALU_OR    = 6'h01;
   localparam logic [5:0] ALU_ADD   = 6'h02;
   localparam logic [5:0] ALU_ADDU  = 6'h03;
   localparam logic [5:0] ALU_XOR   = 6'h04;
   localparam logic [5:0] ALU_NOR   = 6'h05;
   localparam logic [5:0] ALU_SUB   = 6'h06;
   localparam logic [5:0] ALU_SUBU  = 6'h07;
   localparam logic [5:0] ALU_SLT   = 6'h08;
   localparam logic [5:0] ALU_SLTU  = 6'h09;
   localparam logic [5:0] ALU_SLL   = 6'h0A;
   localparam logic [5:0] ALU_SRL   = 6'h0B;
   localparam logic [5:0] ALU_SRA   = 6'h0C;
   localparam logic [5:0] ALU_SLLV  = 6'h0D;
   localparam logic [5:0] ALU_SRLV  = 6'h0E;
   localparam logic [5:0] ALU_SRAV  = 6'h0F;
   localparam logic [5:0] ALU_LUI   = 6'h10;
   localparam logic [5:0] ALU_MULT  = 6'h11;
   localparam logic [5:0] ALU_MULTU = 6'h12;
   localparam logic [5:0] ALU_DIV   = 6'h13;
   localparam logic [5:0] ALU_DIVU  = 6'h14;
   localparam logic [5:0] ALU_MFHI  = 6'h15;
   localparam logic [5:0] ALU_MFLO  = 6'h16;
   localparam logic [5:0] ALU_MTHI  = 6'h17;
   localparam logic [5:0] ALU_MTLO  = 6'h18;
   localparam logic [5:0] ALU_PASSA = 6'h19;
   localparam logic [5:0] ALU_PASSB = 6'h1A;

   function automatic logic writes_hilo(input logic [5:0] code);
      logic hit;
      case (code)
         ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU, ALU_MTHI, ALU_MTLO: hit = 1'b1;
         default:                                                   hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/alu_hilo.sv
// HI/LO architectural registers with the multiply and single-cycle divide datapath.
// Divide by zero leaves both registers untouched.
module alu_hilo
   import alu_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [5:0]          ctrl,
   input  logic [DATA_W-1:0]   op_a,
   input  logic [DATA_W-1:0]   op_b,
   output logic [DATA_W-1:0]   hi,
   output logic [DATA_W-1:0]   lo
);

   logic [DATA_W-1:0]   hi_r;
   logic [DATA_W-1:0]   lo_r;
   logic [DATA_W-1:0]   hi_nxt_s;
   logic [DATA_W-1:0]   lo_nxt_s;
   logic                mul_signed_s;
   logic [2*DATA_W-1:0] mul_a_s;
   logic [2*DATA_W-1:0] mul_b_s;
   logic [2*DATA_W-1:0] prod_s;
   logic                div_signed_s;
   logic                a_neg_s;
   logic                b_neg_s;
   logic [DATA_W-1:0]   abs_a_s;
   logic [DATA_W-1:0]   abs_b_s;
   logic [DATA_W-1:0]   divisor_s;
   logic [DATA_W-1:0]   uquot_s;
   logic [DATA_W-1:0]   urem_s;
   logic [DATA_W-1:0]   quot_s;
   logic [DATA_W-1:0]   rem_s;
   logic                div_zero_s;

   // Multiply: the low 64 bits of the extended product give both signed and unsigned results.
   always_comb begin
      mul_signed_s = (ctrl == ALU_MULT);
      if (mul_signed_s) begin
         mul_a_s = {{DATA_W{op_a[DATA_W-1]}}, op_a};
         mul_b_s = {{DATA_W{op_b[DATA_W-1]}}, op_b};
      end else begin
         mul_a_s = {{DATA_W{1'b0}}, op_a};
         mul_b_s = {{DATA_W{1'b0}}, op_b};
      end
      prod_s = mul_a_s * mul_b_s;
   end

   // Divide on magnitudes then restore signs; this also yields 0x80000000/-1 = 0x80000000 rem 0.
   always_comb begin
      div_signed_s = (ctrl == ALU_DIV);
      div_zero_s   = (op_b == {DATA_W{1'b0}});
      a_neg_s      = div_signed_s & op_a[DATA_W-1];
      b_neg_s      = div_signed_s & op_b[DATA_W-1];
      abs_a_s      = a_neg_s ? (~op_a + 32'd1) : op_a;
      abs_b_s      = b_neg_s ? (~op_b + 32'd1) : op_b;
      divisor_s    = div_zero_s ? 32'd1 : abs_b_s;
      uquot_s      = abs_a_s / divisor_s;
      urem_s       = abs_a_s % divisor_s;
      if (a_neg_s ^ b_neg_s) begin
         quot_s = ~uquot_s + 32'd1;
      end else begin
         quot_s = uquot_s;
      end
      if (a_neg_s) begin
         rem_s = ~urem_s + 32'd1;
      end else begin
         rem_s = urem_s;
      end
   end

   // Next-state selection for HI/LO; everything not listed holds.
   always_comb begin
      hi_nxt_s = hi_r;
      lo_nxt_s = lo_r;
      if (writes_hilo(ctrl)) begin
         case (ctrl)
            ALU_MULT, ALU_MULTU: begin
               hi_nxt_s = prod_s[2*DATA_W-1:DATA_W];
               lo_nxt_s = prod_s[DATA_W-1:0];
            end
            ALU_DIV, ALU_DIVU: begin
               if (!div_zero_s) begin
                  hi_nxt_s = rem_s;
                  lo_nxt_s = quot_s;
               end else begin
                  hi_nxt_s = hi_r;
                  lo_nxt_s = lo_r;
               end
            end
            ALU_MTHI: hi_nxt_s = op_a;
            ALU_MTLO: lo_nxt_s = op_a;
            default: begin
               hi_nxt_s = hi_r;
               lo_nxt_s = lo_r;
            end
         endcase
      end else begin
         hi_nxt_s = hi_r;
         lo_nxt_s = lo_r;
      end
   end

   // HI/LO state, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_r <= 32'h0000_0000;
         lo_r <= 32'h0000_0000;
      end else begin
         hi_r <= hi_nxt_s;
         lo_r <= lo_nxt_s;
      end
   end

   assign hi = hi_r;
   assign lo = lo_r;

endmodule

// File: rtl/alu.sv
// 32-bit MIPS-style ALU: combinational result path plus HI/LO owned by alu_hilo.
// Shifts, logic and compares live here; mult/div state lives in the sub-module.
module alu
   import alu_pkg::*;
(
   input  logic                CLK,
   input  logic                RESET,
   output logic [DATA_W-1:0]   HI,
   output logic [DATA_W-1:0]   LO,
   output logic [DATA_W-1:0]   aluResult,
   input  logic [DATA_W-1:0]   OpA,
   input  logic [DATA_W-1:0]   OpB,
   input  logic [5:0]          ALU_control,
   input  logic [4:0]          shamt
);

   logic [DATA_W-1:0] hi_s;
   logic [DATA_W-1:0] lo_s;
   logic [4:0]        var_amt_s;
   logic              slt_s;
   logic              sltu_s;

   alu_hilo u_hilo (
      .clk   (CLK),
      .rst_n (RESET),
      .ctrl  (ALU_control),
      .op_a  (OpA),
      .op_b  (OpB),
      .hi    (hi_s),
      .lo    (lo_s)
   );

   assign HI = hi_s;
   assign LO = lo_s;

   // Result mux; mult/div/move-to codes and undefined codes produce zero.
   always_comb begin
      var_amt_s = OpA[4:0];
      slt_s     = ($signed(OpA) < $signed(OpB));
      sltu_s    = (OpA < OpB);
      aluResult = 32'h0000_0000;
      case (ALU_control)
         ALU_AND:   aluResult = OpA & OpB;
         ALU_OR:    aluResult = OpA | OpB;
         ALU_ADD,
         ALU_ADDU:  aluResult = OpA + OpB;
         ALU_XOR:   aluResult = OpA ^ OpB;
         ALU_NOR:   aluResult = ~(OpA | OpB);
         ALU_SUB,
         ALU_SUBU:  aluResult = OpA - OpB;
         ALU_SLT:   aluResult = {31'd0, slt_s};
         ALU_SLTU:  aluResult = {31'd0, sltu_s};
         ALU_SLL:   aluResult = OpB << shamt;
         ALU_SRL:   aluResult = OpB >> shamt;
         ALU_SRA:   aluResult = $signed(OpB) >>> shamt;
         ALU_SLLV:  aluResult = OpB << var_amt_s;
         ALU_SRLV:  aluResult = OpB >> var_amt_s;
         ALU_SRAV:  aluResult = $signed(OpB) >>> var_amt_s;
         ALU_LUI:   aluResult = {OpB[15:0], 16'h0000};
         ALU_MFHI:  aluResult = hi_s;
         ALU_MFLO:  aluResult = lo_s;
         ALU_PASSA: aluResult = OpA;
         ALU_PASSB: aluResult = OpB;
         default:   aluResult = 32'h0000_0000;
      endcase
   end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases plus random ops checked against an arithmetic model.
`timescale 1ns/1ps
module tb_alu;

   logic        CLK;
   logic        RESET;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] aluResult;
   logic [31:0] OpA;
   logic [31:0] OpB;
   logic [5:0]  ALU_control;
   logic [4:0]  shamt;

   int checks;
   int failures;
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   alu dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .HI          (HI),
      .LO          (LO),
      .aluResult   (aluResult),
      .OpA         (OpA),
      .OpB         (OpB),
      .ALU_control (ALU_control),
      .shamt       (shamt)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic logic [31:0] sra32(input logic [31:0] v, input int n);
      logic [31:0] ones;
      ones = 32'hFFFF_FFFF;
      return (v >> n) | (v[31] ? ~(ones >> n) : 32'h0);
   endfunction

   function automatic logic [31:0] model_result(input logic [5:0] c, input logic [31:0] a,
                                                input logic [31:0] b, input logic [4:0] s);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (c)
         6'h00: return a & b;
         6'h01: return a | b;
         6'h02, 6'h03: return 32'(longint'(a) + longint'(b));
         6'h04: return a ^ b;
         6'h05: return ~(a | b);
         6'h06, 6'h07: return 32'(longint'(a) - longint'(b));
         6'h08: return (sa < sb) ? 32'd1 : 32'd0;
         6'h09: return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
         6'h0A: return 32'(longint'(a) * 0 + (longint'(b) << s));
         6'h0B: return b >> s;
         6'h0C: return sra32(b, int'(s));
         6'h0D: return 32'(longint'(b) << (a % 32));
         6'h0E: return b >> (a % 32);
         6'h0F: return sra32(b, int'(a % 32));
         6'h10: return b * 32'd65536;
         6'h15: return m_hi;
         6'h16: return m_lo;
         6'h19: return a;
         6'h1A: return b;
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_update(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, sq, sr;
      longint unsigned up;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (c)
         6'h11: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
         6'h12: begin
            up = longint'(a) * longint'(b);
            p = 64'(up); m_hi = p[63:32]; m_lo = p[31:0];
         end
         6'h13: if (b != 32'd0) begin
            sq = sa / sb; sr = sa % sb;
            m_lo = 32'(sq); m_hi = 32'(sr);
         end
         6'h14: if (b != 32'd0) begin
            m_lo = a / b; m_hi = a % b;
         end
         6'h17: m_hi = a;
         6'h18: m_lo = a;
         default: ;
      endcase
   endtask

   task automatic drive(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] s);
      @(negedge CLK);
      ALU_control = c;
      OpA = a;
      OpB = b;
      shamt = s;
      #1;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
      model_update(ALU_control, OpA, OpB);
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      ALU_control = 6'h3F; OpA = 32'h0; OpB = 32'h0; shamt = 5'd0;
      #2 RESET = 1'b0;
      #1;
      m_hi = 32'h0; m_lo = 32'h0;
      checks++;
      if (HI !== 32'h0 || LO !== 32'h0) begin
         failures++; $display("FAIL reset_init HI=%h LO=%h expected 0/0", HI, LO);
      end
      @(negedge CLK); RESET = 1'b1;
      drive(6'h17, 32'h1111_2222, 32'h0, 5'd0); tick();
      drive(6'h18, 32'h3333_4444, 32'h0, 5'd0); tick();
      checks++;
      if (HI !== 32'h1111_2222 || LO !== 32'h3333_4444) begin
         failures++; $display("FAIL reset_pre_write HI=%h LO=%h", HI, LO);
      end
      drive(6'h15, 32'h0, 32'h0, 5'd0);
      #2 RESET = 1'b0;
      #1;
      m_hi = 32'h0; m_lo = 32'h0;
      checks++;
      if (HI !== 32'h0 || LO !== 32'h0) begin
         failures++; $display("FAIL reset_async HI=%h LO=%h expected 0/0", HI, LO);
      end
      checks++;
      if (aluResult !== 32'h0) begin
         failures++; $display("FAIL reset_mfhi result=%h expected 0", aluResult);
      end
      drive(6'h17, 32'hCAFE_F00D, 32'h0, 5'd0);
      RESET = 1'b1;
      tick();
      checks++;
      if (HI !== 32'hCAFE_F00D) begin
         failures++; $display("FAIL reset_release_update HI=%h expected cafef00d", HI);
      end
   endtask

   task automatic test_arith();
      logic [5:0]  c [6];
      logic [31:0] a [6];
      logic [31:0] b [6];
      logic [31:0] e [6];
      c = '{6'h02, 6'h06, 6'h08, 6'h09, 6'h05, 6'h3F};
      a = '{32'h7FFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1234_5678};
      b = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h0, 32'h9ABC_DEF0};
      e = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'hFFFF_FFFF, 32'h0};
      for (int i = 0; i < 6; i++) begin
         drive(c[i], a[i], b[i], 5'd0);
         checks++;
         if (aluResult !== e[i]) begin
            failures++; $display("FAIL arith_%0d code=%h result=%h expected %h", i, c[i], aluResult, e[i]);
         end
      end
   endtask

   task automatic test_shift();
      logic [5:0]  c [5];
      logic [31:0] a [5];
      logic [31:0] b [5];
      logic [4:0]  s [5];
      logic [31:0] e [5];
      c = '{6'h0A, 6'h0C, 6'h0E, 6'h10, 6'h0F};
      a = '{32'h0, 32'h0, 32'h24, 32'h0, 32'hFFFF_FFE0};
      b = '{32'h1, 32'h8000_0000, 32'hF0, 32'h1234, 32'h8765_4321};
      s = '{5'd31, 5'd4, 5'd0, 5'd0, 5'd7};
      e = '{32'h8000_0000, 32'hF800_0000, 32'h0F, 32'h1234_0000, 32'h8765_4321};
      for (int i = 0; i < 5; i++) begin
         drive(c[i], a[i], b[i], s[i]);
         checks++;
         if (aluResult !== e[i]) begin
            failures++; $display("FAIL shift_%0d code=%h result=%h expected %h", i, c[i], aluResult, e[i]);
         end
      end
   endtask

   task automatic test_muldiv();
      logic [5:0]  c [6];
      logic [31:0] a [6];
      logic [31:0] b [6];
      logic [31:0] eh [6];
      logic [31:0] el [6];
      c  = '{6'h11, 6'h12, 6'h13, 6'h14, 6'h13, 6'h13};
      a  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h7, 32'h55, 32'h8000_0000};
      b  = '{32'h2, 32'h2, 32'h2, 32'h2, 32'h0, 32'hFFFF_FFFF};
      eh = '{32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'h1, 32'h1, 32'h0};
      el = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h3, 32'h3, 32'h8000_0000};
      for (int i = 0; i < 6; i++) begin
         drive(c[i], a[i], b[i], 5'd0);
         checks++;
         if (aluResult !== 32'h0) begin
            failures++; $display("FAIL muldiv_res_%0d result=%h expected 0", i, aluResult);
         end
         tick();
         checks++;
         if (HI !== eh[i] || LO !== el[i]) begin
            failures++; $display("FAIL muldiv_%0d HI=%h LO=%h expected %h/%h", i, HI, LO, eh[i], el[i]);
         end
         if (i == 1) begin
            drive(6'h15, 32'h0, 32'h0, 5'd0);
            checks++;
            if (aluResult !== 32'h1) begin
               failures++; $display("FAIL mfhi_after_multu result=%h expected 1", aluResult);
            end
            drive(6'h16, 32'h0, 32'h0, 5'd0);
            checks++;
            if (aluResult !== 32'hFFFF_FFFE) begin
               failures++; $display("FAIL mflo_after_multu result=%h expected fffffffe", aluResult);
            end
         end
      end
   endtask

   task automatic test_move();
      drive(6'h17, 32'hA5A5_A5A5, 32'h0, 5'd0); tick();
      drive(6'h02, 32'h1, 32'h2, 5'd0); tick();
      drive(6'h18, 32'h5A5A_5A5A, 32'h0, 5'd0); tick();
      drive(6'h02, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0); tick();
      drive(6'h15, 32'h0, 32'h0, 5'd0);
      checks++;
      if (aluResult !== 32'hA5A5_A5A5) begin
         failures++; $display("FAIL move_mfhi result=%h expected a5a5a5a5", aluResult);
      end
      drive(6'h16, 32'h0, 32'h0, 5'd0);
      checks++;
      if (aluResult !== 32'h5A5A_5A5A) begin
         failures++; $display("FAIL move_mflo result=%h expected 5a5a5a5a", aluResult);
      end
   endtask

   task automatic test_random();
      logic [5:0]  c;
      logic [31:0] a, b, exp_r;
      logic [4:0]  s;
      for (int i = 0; i < 300; i++) begin
         c = 6'($urandom_range(0, 27));
         if (c == 6'd27) c = 6'h20 + 6'($urandom_range(0, 31));
         a = $urandom;
         b = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
         s = 5'($urandom_range(0, 31));
         drive(c, a, b, s);
         exp_r = model_result(c, a, b, s);
         checks++;
         if (aluResult !== exp_r) begin
            failures++; $display("FAIL rand_res_%0d code=%h a=%h b=%h result=%h expected %h", i, c, a, b, aluResult, exp_r);
         end
         tick();
         checks++;
         if (HI !== m_hi || LO !== m_lo) begin
            failures++; $display("FAIL rand_hilo_%0d code=%h HI=%h LO=%h expected %h/%h", i, c, HI, LO, m_hi, m_lo);
         end
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      m_hi = 32'h0;
      m_lo = 32'h0;
      test_reset();
      test_arith();
      test_shift();
      test_muldiv();
      test_move();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
